fb_write_arbiter: RTL
=====================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of pixel-write requesters.
REQ-002 SHALL have parameter FB_LIMIT, default FRAMEBUFFER_SIZE: first out-of-range pixel address.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clock  in  1: single clock.
- reset  in  1: asynchronous, active-high.
- vsync  in  1: frame sync, synchronous to clock.
- fb_resetting  in  1: framebuffer clear in progress.
- req_valid  in  NUM_REQ: per-requester write valid.
- req_last  in  NUM_REQ: marks the requester's final write of the frame.
- req_addr  in  NUM_REQ x 19: pixel address.
- req_data  in  NUM_REQ x 4: pixel colour.
- req_ready  out  NUM_REQ: write accepted this cycle.
- addr_wr1  out  19: write port 1 address.
- data_wr1  out  4: write port 1 data.
- wr1_en  out  1: write port 1 enable.
- addr_wr2  out  19: write port 2 address.
- data_wr2  out  4: write port 2 data.
- wr2_en  out  1: write port 2 enable.
- frame_ready  out  1: all requesters done, waiting for swap.
- overrun_count  out  8: frames swapped before completion, saturating.
- drop_count  out  16: out-of-range writes discarded, saturating.

Function
REQ-004 SHALL implement a state machine with states DRAW, DONE and WAIT_RESET.
REQ-005 SHALL detect a vsync falling edge as old_vsync=1 and vsync=0, with old_vsync registered every cycle.
REQ-006 SHALL grant writes only in DRAW, and only to requesters whose done flag is clear.
REQ-007 SHALL grant at most two requesters per cycle, in round-robin order starting at pointer rr: the first eligible valid requester gets port 1, the second gets port 2.
REQ-008 SHALL drive req_ready combinationally from state, done flags, req_valid and rr; a transfer is valid&ready in the same cycle.
REQ-009 SHALL, when at least one grant is made, advance rr to one past the index of the last granted requester, modulo NUM_REQ; otherwise rr is unchanged.
REQ-010 SHALL register port outputs, giving exactly 1 cycle of latency from transfer to wrN_en high; the enable is low in any cycle without a corresponding transfer.
REQ-011 SHALL accept a transfer with addr >= FB_LIMIT (ready=1) but issue no write for it, and SHALL increment drop_count, saturating at 0xFFFF.
REQ-012 SHALL set a requester's done flag on any transfer with req_last=1, including a dropped one.
REQ-013 SHALL go DRAW -> DONE in the cycle after all done flags become set; frame_ready=1 only in DONE.
REQ-014 SHALL go DONE -> WAIT_RESET on a vsync falling edge, and clear all done flags.
REQ-015 SHALL, on a vsync falling edge in DRAW, go to WAIT_RESET, clear all done flags and increment overrun_count, saturating at 0xFF.
REQ-016 SHALL still emit any transfers made in the edge cycle of REQ-015 on the next cycle.
REQ-017 SHALL go WAIT_RESET -> DRAW only after fb_resetting has been sampled 1 and then 0, using a seen flag cleared on entry.
REQ-018 SHALL ignore vsync edges that occur in WAIT_RESET.
REQ-019 SHALL keep req_ready all 0 when NUM_REQ requesters are all done or none is valid; wr1_en and wr2_en are then 0 in the following cycle.

Reset
REQ-020 SHALL, on asynchronous reset assertion, immediately set: state=DRAW, rr=0, done flags=0, seen flag=0, old_vsync=1.
REQ-021 SHALL, on the same assertion, set all port outputs to 0, frame_ready=0, overrun_count=0 and drop_count=0.
REQ-022 SHALL, when reset is asserted mid-operation, discard in-flight registered writes, so enables read 0 on the next clock edge.

Structure
REQ-023 SHALL place the state enum, address width 19, data width 4 and the NUM_REQ default in package fb_arb_pkg; FRAMEBUFFER_SIZE comes from params.vh.
REQ-024 SHALL use one combinational sub-module, rr_pick2, which returns two one-hot grants plus their indices given a valid mask and rr.

Verification
REQ-025 SHALL cover: all three requesters valid, rr=0 -> grants to 0 (port 1) and 1 (port 2); the next cycle grants to 2 and 0; rr sequence 0,2,1.
REQ-026 SHALL cover: requester 1 writes addr 0x12345 with data 0xA -> addr_wr1=0x12345, data_wr1=0xA, wr1_en=1 exactly one cycle later.
REQ-027 SHALL cover: an addr equal to FB_LIMIT -> ready=1, no enable, drop_count 0->1.
REQ-028 SHALL cover: all three requesters send last -> frame_ready=1 the next cycle; a vsync fall then fb_resetting 1 for 5 cycles then 0 -> DRAW, with ready possible the cycle after.
REQ-029 SHALL cover: a vsync fall while requester 2 is not done -> overrun_count=1, WAIT_RESET; overrun_count held at 255 after 300 such frames.
REQ-030 SHALL cover: reset pulsed while wr1_en=1 -> all outputs 0 immediately, state DRAW, rr=0.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Types and constants shared by the framebuffer write arbiter.
`include "params.vh"

package fb_arb_pkg;

    localparam int ADDR_W           = 19;
    localparam int DATA_W           = 4;
    localparam int NUM_REQ_DEF      = 3;
    localparam int FRAMEBUFFER_SIZE = `FRAMEBUFFER_SIZE;

    typedef enum logic [1:0] {
        DRAW,
        DONE,
        WAIT_RESET
    } state_t;

endpackage

// File: rtl/params.vh
// Shared build-time constants for the framebuffer subsystem.
`ifndef FB_PARAMS_VH
`define FB_PARAMS_VH
`define FRAMEBUFFER_SIZE 307200
`endif

// File: rtl/rr_pick2.sv
// Combinational round-robin picker: first two set bits of mask from rr.
module rr_pick2 #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  g1,
    output logic [N-1:0]  g2,
    output logic [IW-1:0] idx1,
    output logic [IW-1:0] idx2,
    output logic          any1,
    output logic          any2
);

    always_comb begin
        int j;
        j    = 0;
        g1   = '0;
        g2   = '0;
        idx1 = '0;
        idx2 = '0;
        any1 = 1'b0;
        any2 = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(rr) + k) % N;
            if (mask[j]) begin
                if (!any1) begin
                    any1  = 1'b1;
                    g1[j] = 1'b1;
                    idx1  = IW'(j);
                end else if (!any2) begin
                    any2  = 1'b1;
                    g2[j] = 1'b1;
                    idx2  = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Merges per-requester pixel writes onto two framebuffer write ports
// and tracks frame completion against vsync.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int FB_LIMIT = FRAMEBUFFER_SIZE
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            vsync,
    input  logic                            fb_resetting,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [ADDR_W-1:0]               addr_wr1,
    output logic [DATA_W-1:0]               data_wr1,
    output logic                            wr1_en,
    output logic [ADDR_W-1:0]               addr_wr2,
    output logic [DATA_W-1:0]               data_wr2,
    output logic                            wr2_en,
    output logic                            frame_ready,
    output logic [7:0]                      overrun_count,
    output logic [15:0]                     drop_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] LIM = 32'(FB_LIMIT);

    state_t               state;
    logic [NUM_REQ-1:0]   done;
    logic                 seen;
    logic                 old_vsync;
    logic [IW-1:0]        rr;

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   g1;
    logic [NUM_REQ-1:0]   g2;
    logic [IW-1:0]        i1;
    logic [IW-1:0]        i2;
    logic                 f1;
    logic                 f2;
    logic                 fall;
    logic                 ok1;
    logic                 ok2;
    logic [1:0]           ndrop;
    logic [16:0]          drop_sum;
    logic [NUM_REQ-1:0]   done_nx;
    logic [IW-1:0]        rr_nx;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (32'(i) + 32'd1 >= 32'(NUM_REQ))
            return '0;
        return i + 1'b1;
    endfunction

    assign elig = (state == DRAW) ? (req_valid & ~done) : '0;

    rr_pick2 #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .mask (elig),
        .rr   (rr),
        .g1   (g1),
        .g2   (g2),
        .idx1 (i1),
        .idx2 (i2),
        .any1 (f1),
        .any2 (f2)
    );

    assign req_ready = g1 | g2;
    assign fall      = old_vsync & ~vsync;

    // Out-of-range transfers are accepted but never reach a port.
    assign ok1      = f1 & (32'(req_addr[i1]) < LIM);
    assign ok2      = f2 & (32'(req_addr[i2]) < LIM);
    assign ndrop    = {1'b0, f1 & ~ok1} + {1'b0, f2 & ~ok2};
    assign drop_sum = {1'b0, drop_count} + 17'(ndrop);

    assign done_nx = done | (req_ready & req_last);
    assign rr_nx   = f2 ? wrap_inc(i2) : (f1 ? wrap_inc(i1) : rr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= DRAW;
            done          <= '0;
            seen          <= 1'b0;
            old_vsync     <= 1'b1;
            rr            <= '0;
            addr_wr1      <= '0;
            data_wr1      <= '0;
            wr1_en        <= 1'b0;
            addr_wr2      <= '0;
            data_wr2      <= '0;
            wr2_en        <= 1'b0;
            frame_ready   <= 1'b0;
            overrun_count <= '0;
            drop_count    <= '0;
        end else begin
            old_vsync  <= vsync;
            rr         <= rr_nx;
            addr_wr1   <= req_addr[i1];
            data_wr1   <= req_data[i1];
            wr1_en     <= ok1;
            addr_wr2   <= req_addr[i2];
            data_wr2   <= req_data[i2];
            wr2_en     <= ok2;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            unique case (state)
                DRAW: begin
                    if (fall) begin
                        state       <= WAIT_RESET;
                        done        <= '0;
                        seen        <= 1'b0;
                        frame_ready <= 1'b0;
                        if (overrun_count != 8'hFF)
                            overrun_count <= overrun_count + 8'd1;
                    end else if (&done_nx) begin
                        state       <= DONE;
                        done        <= done_nx;
                        frame_ready <= 1'b1;
                    end else begin
                        done <= done_nx;
                    end
                end
                DONE: begin
                    if (fall) begin
                        state       <= WAIT_RESET;
                        done        <= '0;
                        seen        <= 1'b0;
                        frame_ready <= 1'b0;
                    end
                end
                WAIT_RESET: begin
                    if (fb_resetting) begin
                        seen <= 1'b1;
                    end else if (seen) begin
                        state <= DRAW;
                        seen  <= 1'b0;
                    end
                end
                default: begin
                    state       <= DRAW;
                    frame_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
